// File: rtl/i2c_fnd_mux_slave_pkg.sv
// Shared definitions for the I2C-controlled 7-segment display slave.
//   state_t        : I2C slave FSM state encoding (4 bits, IDLE = 0)
//   FND_DP_BIT     : register bit that lights the digit's decimal point
//   FND_BLANK_BIT  : register bit that blanks the digit
//   hex_to_seg()   : hex nibble to active-low segment pattern {g..a}
package i2c_slave_pkg;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_RX_ADDR   = 4'd1,
        ST_ADDR_ACK  = 4'd2,
        ST_RX_PTR    = 4'd3,
        ST_PTR_ACK   = 4'd4,
        ST_RX_DATA   = 4'd5,
        ST_DATA_ACK  = 4'd6,
        ST_TX_DATA   = 4'd7,
        ST_TX_ACK    = 4'd8,
        ST_WAIT_STOP = 4'd9
    } state_t;

    localparam int FND_DP_BIT    = 4;
    localparam int FND_BLANK_BIT = 5;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] hex);
        logic [6:0] seg;
        case (hex)
            4'h0:    seg = 7'b1000000;
            4'h1:    seg = 7'b1111001;
            4'h2:    seg = 7'b0100100;
            4'h3:    seg = 7'b0110000;
            4'h4:    seg = 7'b0011001;
            4'h5:    seg = 7'b0010010;
            4'h6:    seg = 7'b0000010;
            4'h7:    seg = 7'b1111000;
            4'h8:    seg = 7'b0000000;
            4'h9:    seg = 7'b0010000;
            4'hA:    seg = 7'b0001000;
            4'hB:    seg = 7'b0000011;
            4'hC:    seg = 7'b1000110;
            4'hD:    seg = 7'b0100001;
            4'hE:    seg = 7'b0000110;
            default: seg = 7'b0001110;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/i2c_fnd_mux_slave_scan.sv
// Time-multiplexed scan driver for a common-anode 7-segment display.
//   clk, rst_n : system clock, async active-low reset
//   regs       : packed digit registers, digit i in regs[8*i +: 8]
//   SEG        : active-low segments {g..a} of the digit currently selected
//   DP         : active-low decimal point of the digit currently selected
//   AN         : active-low one-hot anode select
module fnd_scan_driver
    import i2c_slave_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int CLK_HZ     = 100_000_000,
    parameter int DIGIT_HZ   = 1000
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_DIGITS*8-1:0]   regs,
    output logic [6:0]                SEG,
    output logic                      DP,
    output logic [NUM_DIGITS-1:0]     AN
);

    localparam int DWELL = (CLK_HZ / DIGIT_HZ) > 0 ? (CLK_HZ / DIGIT_HZ) : 1;
    localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [7:0]       digit;

    always_comb begin
        cnt_d = cnt_q;
        idx_d = idx_q;
        if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            idx_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            idx_q <= idx_d;
        end
    end

    // Decode straight from the live register, so a write shows up at once.
    assign digit = regs[{idx_q, 3'b000} +: 8];
    assign AN    = ~(NUM_DIGITS'(1) << idx_q);
    assign SEG   = digit[FND_BLANK_BIT] ? 7'h7F : hex_to_seg(digit[3:0]);
    assign DP    = ~digit[FND_DP_BIT];

endmodule

// File: rtl/i2c_fnd_mux_slave.sv
// I2C slave holding one control byte per display digit, with a register
// pointer, auto-increment writes, read-back and repeated START support.
//   clk, rst_n       : system clock, async active-low reset
//   scl, sda         : I2C bus; sda is open-drain (drives 0 or Z only)
//   SEG, DP, AN      : active-low display pins from the scan driver
//   debug_addr_match : this slave was addressed in the current transaction
//   debug_state      : current FSM state encoding
module i2c_fnd_mux_slave
    import i2c_slave_pkg::*;
#(
    parameter logic [6:0] SLAVE_ADDR = 7'h56,
    parameter int         NUM_DIGITS = 4,
    parameter int         CLK_HZ     = 100_000_000,
    parameter int         DIGIT_HZ   = 1000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  scl,
    inout  logic                  sda,
    output logic [6:0]            SEG,
    output logic                  DP,
    output logic [NUM_DIGITS-1:0] AN,
    output logic                  debug_addr_match,
    output logic [3:0]            debug_state
);

    localparam int              PTR_W        = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [PTR_W-1:0] PTR_LAST    = PTR_W'(NUM_DIGITS - 1);
    localparam logic [7:0]      NUM_DIGITS_B = 8'(NUM_DIGITS);

    logic [2:0]              scl_sync_q, scl_sync_d, sda_sync_q, sda_sync_d;
    logic                    scl_prev_q, scl_prev_d, sda_prev_q, sda_prev_d;
    state_t                  state_q, state_d;
    logic [3:0]              bit_count_q, bit_count_d;
    logic [7:0]              rx_shift_q, rx_shift_d;
    logic [7:0]              tx_shift_q, tx_shift_d;
    logic                    sda_drive_q, sda_drive_d;
    logic                    addr_match_q, addr_match_d;
    logic                    master_ack_q, master_ack_d;
    logic [PTR_W-1:0]        ptr_q, ptr_d;
    logic [NUM_DIGITS*8-1:0] regs_q, regs_d;

    logic       scl_s, sda_s, scl_rise, scl_fall, start_det, stop_det;
    logic [7:0] tx_byte;
    logic [PTR_W-1:0] ptr_next;

    assign scl_s     = scl_sync_q[2];
    assign sda_s     = sda_sync_q[2];
    assign scl_rise  = scl_s & ~scl_prev_q;
    assign scl_fall  = ~scl_s & scl_prev_q;
    // Bus conditions need SCL high on both samples so an SCL edge coinciding
    // with an SDA change is never mistaken for START/STOP.
    assign start_det = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
    assign stop_det  = scl_s & scl_prev_q & ~sda_prev_q & sda_s;

    assign tx_byte  = regs_q[{ptr_q, 3'b000} +: 8];
    assign ptr_next = (ptr_q == PTR_LAST) ? '0 : ptr_q + 1'b1;

    always_comb begin
        scl_sync_d   = {scl_sync_q[1:0], scl};
        sda_sync_d   = {sda_sync_q[1:0], sda};
        scl_prev_d   = scl_s;
        sda_prev_d   = sda_s;
        state_d      = state_q;
        bit_count_d  = bit_count_q;
        rx_shift_d   = rx_shift_q;
        tx_shift_d   = tx_shift_q;
        sda_drive_d  = sda_drive_q;
        addr_match_d = addr_match_q;
        master_ack_d = master_ack_q;
        ptr_d        = ptr_q;
        regs_d       = regs_q;

        if (stop_det) begin
            state_d      = ST_IDLE;
            sda_drive_d  = 1'b0;
            bit_count_d  = '0;
            addr_match_d = 1'b0;
        end else if (start_det) begin
            state_d      = ST_RX_ADDR;
            sda_drive_d  = 1'b0;
            bit_count_d  = '0;
            addr_match_d = 1'b0;
        end else begin
            case (state_q)
                ST_RX_ADDR, ST_RX_PTR, ST_RX_DATA: begin
                    if (scl_rise && bit_count_q < 4'd8) begin
                        rx_shift_d  = {rx_shift_q[6:0], sda_s};
                        bit_count_d = bit_count_q + 4'd1;
                    end else if (scl_fall && bit_count_q == 4'd8) begin
                        // The fall ending bit 8 opens the ACK slot.
                        bit_count_d = '0;
                        if (state_q == ST_RX_ADDR) begin
                            if (rx_shift_q[7:1] == SLAVE_ADDR) begin
                                addr_match_d = 1'b1;
                                sda_drive_d  = 1'b1;
                                state_d      = ST_ADDR_ACK;
                            end else begin
                                state_d = ST_WAIT_STOP;
                            end
                        end else if (state_q == ST_RX_PTR) begin
                            if (rx_shift_q < NUM_DIGITS_B) begin
                                ptr_d       = rx_shift_q[PTR_W-1:0];
                                sda_drive_d = 1'b1;
                                state_d     = ST_PTR_ACK;
                            end else begin
                                state_d = ST_WAIT_STOP;
                            end
                        end else begin
                            sda_drive_d = 1'b1;
                            state_d     = ST_DATA_ACK;
                        end
                    end
                end
                ST_ADDR_ACK: begin
                    if (scl_fall) begin
                        if (rx_shift_q[0]) begin
                            sda_drive_d = ~tx_byte[7];
                            tx_shift_d  = {tx_byte[6:0], 1'b0};
                            bit_count_d = 4'd1;
                            ptr_d       = ptr_next;
                            state_d     = ST_TX_DATA;
                        end else begin
                            sda_drive_d = 1'b0;
                            state_d     = ST_RX_PTR;
                        end
                    end
                end
                ST_PTR_ACK: begin
                    if (scl_fall) begin
                        sda_drive_d = 1'b0;
                        state_d     = ST_RX_DATA;
                    end
                end
                ST_DATA_ACK: begin
                    if (scl_fall) begin
                        sda_drive_d                 = 1'b0;
                        regs_d[{ptr_q, 3'b000} +: 8] = {2'b00, rx_shift_q[5:0]};
                        ptr_d                       = ptr_next;
                        state_d                     = ST_RX_DATA;
                    end
                end
                ST_TX_DATA: begin
                    if (scl_fall) begin
                        if (bit_count_q == 4'd8) begin
                            sda_drive_d = 1'b0;
                            bit_count_d = '0;
                            state_d     = ST_TX_ACK;
                        end else begin
                            sda_drive_d = ~tx_shift_q[7];
                            tx_shift_d  = {tx_shift_q[6:0], 1'b0};
                            bit_count_d = bit_count_q + 4'd1;
                        end
                    end
                end
                ST_TX_ACK: begin
                    if (scl_rise) begin
                        master_ack_d = ~sda_s;
                    end else if (scl_fall) begin
                        if (master_ack_q) begin
                            sda_drive_d = ~tx_byte[7];
                            tx_shift_d  = {tx_byte[6:0], 1'b0};
                            bit_count_d = 4'd1;
                            ptr_d       = ptr_next;
                            state_d     = ST_TX_DATA;
                        end else begin
                            sda_drive_d = 1'b0;
                            state_d     = ST_WAIT_STOP;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Sync flops reset to the idle-high bus level so reset never fakes an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_sync_q   <= 3'b111;
            sda_sync_q   <= 3'b111;
            scl_prev_q   <= 1'b1;
            sda_prev_q   <= 1'b1;
            state_q      <= ST_IDLE;
            bit_count_q  <= '0;
            rx_shift_q   <= '0;
            tx_shift_q   <= '0;
            sda_drive_q  <= 1'b0;
            addr_match_q <= 1'b0;
            master_ack_q <= 1'b0;
            ptr_q        <= '0;
            regs_q       <= '0;
        end else begin
            scl_sync_q   <= scl_sync_d;
            sda_sync_q   <= sda_sync_d;
            scl_prev_q   <= scl_prev_d;
            sda_prev_q   <= sda_prev_d;
            state_q      <= state_d;
            bit_count_q  <= bit_count_d;
            rx_shift_q   <= rx_shift_d;
            tx_shift_q   <= tx_shift_d;
            sda_drive_q  <= sda_drive_d;
            addr_match_q <= addr_match_d;
            master_ack_q <= master_ack_d;
            ptr_q        <= ptr_d;
            regs_q       <= regs_d;
        end
    end

    assign sda              = sda_drive_q ? 1'b0 : 1'bz;
    assign debug_addr_match = addr_match_q;
    assign debug_state      = state_q;

    fnd_scan_driver #(
        .NUM_DIGITS (NUM_DIGITS),
        .CLK_HZ     (CLK_HZ),
        .DIGIT_HZ   (DIGIT_HZ)
    ) u_scan (
        .clk   (clk),
        .rst_n (rst_n),
        .regs  (regs_q),
        .SEG   (SEG),
        .DP    (DP),
        .AN    (AN)
    );

endmodule

// File: tb/tb_i2c_fnd_mux_slave.sv
// Directed bench for i2c_fnd_mux_slave: bit-banged I2C master plus checks of
// ACK/NACK, read-back data, bus release and the scanned display outputs.
module tb_i2c_fnd_mux_slave;

    localparam int QP = 200;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic scl = 1'b1;
    logic master_low = 1'b0;
    wire  sda;

    logic [6:0] SEG;
    logic       DP;
    logic [3:0] AN;
    logic       debug_addr_match;
    logic [3:0] debug_state;

    int checks = 0;
    int errors = 0;

    logic mon_active  = 1'b0;
    logic slave_drove = 1'b0;
    logic match_seen  = 1'b0;

    logic       ack;
    logic [7:0] rb;
    logic [7:0] wr1 [5] = '{8'h00, 8'h03, 8'h1A, 8'h27, 8'h0F};

    assign sda = master_low ? 1'b0 : 1'bz;
    pullup (sda);

    always #5 clk = ~clk;

    i2c_fnd_mux_slave #(
        .SLAVE_ADDR (7'h56),
        .NUM_DIGITS (4),
        .CLK_HZ     (1000),
        .DIGIT_HZ   (100)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .scl              (scl),
        .sda              (sda),
        .SEG              (SEG),
        .DP               (DP),
        .AN               (AN),
        .debug_addr_match (debug_addr_match),
        .debug_state      (debug_state)
    );

    // Watches for any slave drive or address match during the foreign-address frame.
    always @(negedge clk) begin
        if (mon_active) begin
            if (sda === 1'b0 && !master_low) slave_drove <= 1'b1;
            if (debug_addr_match === 1'b1) match_seen <= 1'b1;
        end
    end

    // Hard time limit so a stuck bus can never hang the run.
    initial begin
        #3_000_000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic i2c_start();
        master_low = 1'b0;
        #QP; scl = 1'b1;
        #QP; master_low = 1'b1;
        #QP; scl = 1'b0;
        #QP;
    endtask

    task automatic i2c_stop();
        master_low = 1'b1;
        #QP; scl = 1'b1;
        #QP; master_low = 1'b0;
        #QP;
    endtask

    // Sends one byte MSB first and returns the SDA level seen in the ACK slot.
    task automatic applyStimulus(input logic [7:0] b, output logic ack_bit);
        for (int i = 7; i >= 0; i--) begin
            master_low = ~b[i];
            #QP; scl = 1'b1;
            #(2*QP); scl = 1'b0;
            #QP;
        end
        master_low = 1'b0;
        #QP; scl = 1'b1;
        #QP; ack_bit = sda;
        #QP; scl = 1'b0;
        #QP;
    endtask

    // Reads one byte; drive_ack=1 answers with ACK, 0 with NACK.
    task automatic i2c_read(input logic drive_ack, output logic [7:0] b);
        master_low = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            #QP; scl = 1'b1;
            #QP; b[i] = sda;
            #QP; scl = 1'b0;
            #QP;
        end
        master_low = drive_ack;
        #QP; scl = 1'b1;
        #(2*QP); scl = 1'b0;
        #QP; master_low = 1'b0;
    endtask

    task automatic checkDigit(input int idx, input logic [6:0] seg_exp, input logic dp_exp);
        logic [3:0] an_exp;
        an_exp = ~(4'b0001 << idx);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (AN === an_exp) break;
        end
        checkOutput($sformatf("an%0d", idx), 32'(AN), 32'(an_exp));
        checkOutput($sformatf("seg%0d", idx), 32'(SEG), 32'(seg_exp));
        checkOutput($sformatf("dp%0d", idx), 32'(DP), 32'(dp_exp));
        #2;
    endtask

    initial begin
        #2;
        #100;
        checkOutput("rst_sda", 32'(sda), 32'h1);
        checkOutput("rst_an", 32'(AN), 32'hE);
        checkOutput("rst_seg", 32'(SEG), 32'h40);
        checkOutput("rst_dp", 32'(DP), 32'h1);
        checkOutput("rst_state", 32'(debug_state), 32'h0);
        checkOutput("rst_match", 32'(debug_addr_match), 32'h0);
        rst_n = 1'b1;
        #100;

        $display("[TB] burst write of four digits");
        i2c_start();
        applyStimulus(8'hAC, ack);
        checkOutput("t1_addr_ack", 32'(ack), 32'h0);
        checkOutput("t1_match", 32'(debug_addr_match), 32'h1);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(wr1[i], ack);
            checkOutput($sformatf("t1_ack%0d", i), 32'(ack), 32'h0);
        end
        i2c_stop();
        #100;
        checkOutput("t1_state_idle", 32'(debug_state), 32'h0);
        checkOutput("t1_match_clr", 32'(debug_addr_match), 32'h0);
        checkDigit(0, 7'h30, 1'b1);
        checkDigit(1, 7'h08, 1'b0);
        checkDigit(2, 7'h7F, 1'b1);
        checkDigit(3, 7'h0E, 1'b1);
        i2c_start();
        applyStimulus(8'hAD, ack);
        checkOutput("t1_rd_ack", 32'(ack), 32'h0);
        i2c_read(1'b0, rb);
        checkOutput("t1_ptr_wrap", 32'(rb), 32'h03);
        i2c_stop();

        $display("[TB] pointer set then three-byte read");
        i2c_start();
        applyStimulus(8'hAC, ack);
        checkOutput("t2_addr_ack", 32'(ack), 32'h0);
        applyStimulus(8'h02, ack);
        checkOutput("t2_ptr_ack", 32'(ack), 32'h0);
        i2c_stop();
        i2c_start();
        applyStimulus(8'hAD, ack);
        checkOutput("t2_rd_ack", 32'(ack), 32'h0);
        i2c_read(1'b1, rb);
        checkOutput("t2_rd0", 32'(rb), 32'h27);
        i2c_read(1'b1, rb);
        checkOutput("t2_rd1", 32'(rb), 32'h0F);
        i2c_read(1'b0, rb);
        checkOutput("t2_rd2", 32'(rb), 32'h03);
        #QP;
        checkOutput("t2_sda_release", 32'(sda), 32'h1);
        i2c_stop();

        $display("[TB] out-of-range pointer");
        i2c_start();
        applyStimulus(8'hAC, ack);
        checkOutput("t3_addr_ack", 32'(ack), 32'h0);
        applyStimulus(8'h07, ack);
        checkOutput("t3_ptr_nack", 32'(ack), 32'h1);
        applyStimulus(8'h55, ack);
        checkOutput("t3_data_ignored", 32'(ack), 32'h1);
        i2c_stop();
        i2c_start();
        applyStimulus(8'hAD, ack);
        i2c_read(1'b0, rb);
        checkOutput("t3_ptr_kept", 32'(rb), 32'h1A);
        i2c_stop();
        checkDigit(3, 7'h0E, 1'b1);

        $display("[TB] foreign address");
        mon_active = 1'b1;
        i2c_start();
        applyStimulus(8'hA8, ack);
        checkOutput("t4_addr_nack", 32'(ack), 32'h1);
        applyStimulus(8'h00, ack);
        checkOutput("t4_byte_nack", 32'(ack), 32'h1);
        i2c_stop();
        #100;
        mon_active = 1'b0;
        checkOutput("t4_never_drove", 32'(slave_drove), 32'h0);
        checkOutput("t4_never_match", 32'(match_seen), 32'h0);

        $display("[TB] repeated START");
        i2c_start();
        applyStimulus(8'hAC, ack);
        checkOutput("t5_addr_ack", 32'(ack), 32'h0);
        applyStimulus(8'h01, ack);
        checkOutput("t5_ptr_ack", 32'(ack), 32'h0);
        i2c_start();
        applyStimulus(8'hAD, ack);
        checkOutput("t5_sr_ack", 32'(ack), 32'h0);
        i2c_read(1'b0, rb);
        checkOutput("t5_rd", 32'(rb), 32'h1A);
        i2c_stop();

        $display("[TB] reset during read");
        i2c_start();
        applyStimulus(8'hAD, ack);
        checkOutput("t6_rd_ack", 32'(ack), 32'h0);
        for (int i = 0; i < 3; i++) begin
            #QP; scl = 1'b1;
            #(2*QP); scl = 1'b0;
        end
        #QP;
        checkOutput("t6_pre_reset_drive", 32'(sda), 32'h0);
        rst_n = 1'b0;
        #1;
        checkOutput("t6_sda_released", 32'(sda), 32'h1);
        checkOutput("t6_an", 32'(AN), 32'hE);
        checkOutput("t6_seg", 32'(SEG), 32'h40);
        checkOutput("t6_dp", 32'(DP), 32'h1);
        checkOutput("t6_state", 32'(debug_state), 32'h0);
        #49;
        rst_n = 1'b1;
        #100;
        scl = 1'b1;
        #QP;
        i2c_start();
        applyStimulus(8'hAC, ack);
        checkOutput("t6_addr_ack", 32'(ack), 32'h0);
        applyStimulus(8'h00, ack);
        checkOutput("t6_ptr_ack", 32'(ack), 32'h0);
        applyStimulus(8'h05, ack);
        checkOutput("t6_data_ack", 32'(ack), 32'h0);
        i2c_stop();
        checkDigit(0, 7'h12, 1'b1);
        checkDigit(1, 7'h40, 1'b1);
        checkDigit(2, 7'h40, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
